seg7_scanner: RTL and testbench

SEG7_SCANNER -- requirements
Module: seg7_scanner

---
 rtl/seg7_scanner_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 32 +++
 rtl/seg7_scanner.sv | 166 ++++++++++++++++
 tb/tb_seg7_scanner.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scanner_pkg.sv
// Shared definitions for the 4-digit multiplexed seven-segment scanner:
// FSM encoding, digit count and active-low glyph patterns {g,f,e,d,c,b,a}.
package seg7_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_decode
  import seg7_scanner_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  // Table lookup of the glyph for one hex digit
  always_comb begin
    seg_n = SEG_OFF;
    case (nib)
      4'h0: seg_n = GLYPH_0;
      4'h1: seg_n = GLYPH_1;
      4'h2: seg_n = GLYPH_2;
      4'h3: seg_n = GLYPH_3;
      4'h4: seg_n = GLYPH_4;
      4'h5: seg_n = GLYPH_5;
      4'h6: seg_n = GLYPH_6;
      4'h7: seg_n = GLYPH_7;
      4'h8: seg_n = GLYPH_8;
      4'h9: seg_n = GLYPH_9;
      4'hA: seg_n = GLYPH_A;
      4'hB: seg_n = GLYPH_B;
      4'hC: seg_n = GLYPH_C;
      4'hD: seg_n = GLYPH_D;
      4'hE: seg_n = GLYPH_E;
      default: seg_n = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scanner.sv
// Four-digit multiplexed seven-segment scanner. Steps one digit per
// scan_tick with optional all-off blanking between digits, latches the
// displayed frame at digit 0, and registers every output so the display
// changes on the same edge that samples the tick.
module seg7_scanner
  import seg7_scanner_pkg::*;
#(
  parameter int BLANK_TICKS = 1
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_tick,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        lz_suppress,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (BLANK_TICKS < 1) ? 1 : $clog2(BLANK_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BLANK_TICKS);

  // Leading-zero blanking: a digit is dark when it and every digit to its
  // left are zero; the rightmost digit always shows.
  function automatic logic lz_blank(input logic [15:0] d, input logic lz,
                                    input logic [IDX_W-1:0] i);
    logic b;
    case (i)
      2'd3:    b = (d[15:12] == 4'h0);
      2'd2:    b = (d[15:8]  == 8'h00);
      2'd1:    b = (d[15:4]  == 12'h000);
      default: b = 1'b0;
    endcase
    return lz & b;
  endfunction

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               latch;

  logic [15:0]        dig_sh, dig_sh_nxt;
  logic [3:0]         dpm_sh, dpm_sh_nxt;
  logic               lz_sh, lz_sh_nxt;

  logic [3:0]         nib_nxt;
  logic [6:0]         glyph_nxt;
  logic [3:0]         an_nxt;
  logic [6:0]         seg_nxt;
  logic               dp_nxt;

  // Control state: FSM, digit index and blanking counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; enable low forces IDLE regardless of the tick
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (scan_tick) begin
            state_nxt = ST_SHOW;
            idx_nxt   = '0;
            latch     = 1'b1;
          end
        end
        ST_SHOW: begin
          if (scan_tick) begin
            if (BLANK_TICKS == 0) begin
              idx_nxt = idx + IDX_W'(1);
              latch   = (idx == IDX_W'(NUM_DIGITS - 1));
            end else begin
              state_nxt = ST_BLANK;
              cnt_nxt   = CNT_INIT;
            end
          end
        end
        ST_BLANK: begin
          if (scan_tick) begin
            if (cnt <= CNT_W'(1)) begin
              state_nxt = ST_SHOW;
              idx_nxt   = idx + IDX_W'(1);
              cnt_nxt   = '0;
              latch     = (idx == IDX_W'(NUM_DIGITS - 1));
            end else begin
              cnt_nxt = cnt - CNT_W'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // The outputs of a latching edge must already use the new frame values
  assign dig_sh_nxt = latch ? digits      : dig_sh;
  assign dpm_sh_nxt = latch ? dp_mask     : dpm_sh;
  assign lz_sh_nxt  = latch ? lz_suppress : lz_sh;
  assign nib_nxt    = dig_sh_nxt[{idx_nxt, 2'b00} +: 4];

  seg7_decode u_decode (
    .nib   (nib_nxt),
    .seg_n (glyph_nxt)
  );

  // Output values for the state being entered on this edge
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (state_nxt == ST_SHOW) begin
      an_nxt[idx_nxt] = 1'b0;
      seg_nxt = lz_blank(dig_sh_nxt, lz_sh_nxt, idx_nxt) ? SEG_OFF : glyph_nxt;
      dp_nxt  = ~dpm_sh_nxt[idx_nxt];
    end
  end

  // Frame shadow registers, loaded only at a frame latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sh <= '0;
      dpm_sh <= '0;
      lz_sh  <= 1'b0;
    end else begin
      dig_sh <= dig_sh_nxt;
      dpm_sh <= dpm_sh_nxt;
      lz_sh  <= lz_sh_nxt;
    end
  end

  // Registered display outputs; reset blanks the display immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      frame_start <= latch;
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
// Testbench for seg7_scanner: two instances (one blanking tick, no blanking)
// sharing stimulus, checked against a slot-position reference model.
module tb_seg7_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_tick;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        lz_suppress;

  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0, fs1, fs0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_scanner #(.BLANK_TICKS(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .enable(enable),
    .digits(digits), .dp_mask(dp_mask), .lz_suppress(lz_suppress),
    .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1)
  );

  seg7_scanner #(.BLANK_TICKS(0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .enable(enable),
    .digits(digits), .dp_mask(dp_mask), .lz_suppress(lz_suppress),
    .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0)
  );

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: a frame is a ring of 4*(B+1) tick slots; slot
  // positions that are multiples of (B+1) show a digit, the rest are dark.
  int          m_blank [2] = '{1, 0};
  bit          m_act   [2];
  int          m_pos   [2];
  logic [15:0] m_dig   [2];
  logic [3:0]  m_dpm   [2];
  bit          m_lz    [2];
  bit          m_fs    [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_act[k] = 0; m_pos[k] = 0; m_dig[k] = '0; m_dpm[k] = '0;
        m_lz[k] = 0;  m_fs[k] = 0;
      end else begin
        m_fs[k] = 0;
        if (!enable) begin
          m_act[k] = 0;
        end else if (scan_tick) begin
          if (!m_act[k]) begin
            m_act[k] = 1;
            m_pos[k] = 0;
          end else begin
            m_pos[k] = (m_pos[k] + 1) % (4 * (m_blank[k] + 1));
          end
          if (m_pos[k] == 0) begin
            m_dig[k] = digits; m_dpm[k] = dp_mask; m_lz[k] = lz_suppress;
            m_fs[k]  = 1;
          end
        end
      end
    end
  end

  // Expected {an, seg, dp, frame_start} of instance k
  function automatic logic [12:0] exp_out(input int k);
    logic [3:0] a = 4'b1111;
    logic [6:0] s = 7'b1111111;
    logic       p = 1'b1;
    int d;
    if (m_act[k] && (m_pos[k] % (m_blank[k] + 1)) == 0) begin
      d = m_pos[k] / (m_blank[k] + 1);
      a[d] = 1'b0;
      if (m_lz[k] && d != 0 && (m_dig[k] >> (4 * d)) == 16'h0) s = 7'b1111111;
      else s = glyph[m_dig[k][4*d +: 4]];
      p = ~m_dpm[k][d];
    end
    return {a, s, p, m_fs[k]};
  endfunction

  function automatic logic [12:0] act_out(input int k);
    return (k == 0) ? {an1, seg1, dp1, fs1} : {an0, seg0, dp0, fs0};
  endfunction

  task automatic step(input bit t);
    scan_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    scan_tick = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (act_out(k) !== 13'b1111_1111111_1_0) begin
        n_fail++;
        $display("FAIL reset inst%0d: got %b want %b", k, act_out(k), 13'b1111_1111111_1_0);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_1234();
    enable = 1; digits = 16'h1234; lz_suppress = 0; dp_mask = 4'b0000;
    do_reset();
    step(1);
    n_cmp++;
    if ({an1, seg1, dp1, fs1} !== {4'b1110, 7'b0011001, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL basic_d0: got %b %b %b %b want 1110 0011001 1 1", an1, seg1, dp1, fs1);
    end
    step(1);
    n_cmp++;
    if ({an1, seg1, fs1} !== {4'b1111, 7'b1111111, 1'b0}) begin
      n_fail++; $display("FAIL basic_blank: got %b %b %b want 1111 1111111 0", an1, seg1, fs1);
    end
    step(1);
    n_cmp++;
    if ({an1, seg1, fs1} !== {4'b1101, 7'b0110000, 1'b0}) begin
      n_fail++; $display("FAIL basic_d1: got %b %b %b want 1101 0110000 0", an1, seg1, fs1);
    end
  endtask

  task automatic test_lz_suppress();
    logic [6:0] want_seg [4] = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
    logic       want_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    enable = 1; digits = 16'h0050; lz_suppress = 1; dp_mask = 4'b0100;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1);
      n_cmp++;
      if ({seg0, dp0} !== {want_seg[i], want_dp[i]} || an0[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL lz_digit%0d: got an=%b seg=%b dp=%b want seg=%b dp=%b", i, an0, seg0, dp0, want_seg[i], want_dp[i]);
      end
    end
  endtask

  task automatic test_shadow();
    enable = 1; digits = 16'h1111; lz_suppress = 0; dp_mask = 4'b0000;
    do_reset();
    step(1); step(1); step(1);
    digits = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) step(1); else step(0);
      n_cmp++;
      if (seg0 !== 7'b1111001 || fs0 !== 1'b0) begin
        n_fail++; $display("FAIL shadow_hold%0d: got seg=%b fs=%b want 1111001 0", i, seg0, fs0);
      end
    end
    step(1);
    n_cmp++;
    if ({an0, seg0, fs0} !== {4'b1110, 7'b0100100, 1'b1}) begin
      n_fail++; $display("FAIL shadow_new: got %b %b %b want 1110 0100100 1", an0, seg0, fs0);
    end
  endtask

  task automatic test_no_blank();
    logic [3:0] want_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int fs_cnt = 0;
    enable = 1; digits = 16'h9876; lz_suppress = 0; dp_mask = 4'b0000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1);
      fs_cnt += fs0;
      n_cmp++;
      if (an0 !== want_an[i % 4]) begin
        n_fail++; $display("FAIL noblank_an%0d: got %b want %b", i, an0, want_an[i % 4]);
      end
    end
    n_cmp++;
    if (fs_cnt !== 2) begin
      n_fail++; $display("FAIL noblank_frames: got %0d want 2", fs_cnt);
    end
  endtask

  task automatic test_enable_and_reset();
    enable = 1; digits = 16'h4321; lz_suppress = 0; dp_mask = 4'b1111;
    do_reset();
    step(1); step(1);
    enable = 0;
    step(0);
    n_cmp++;
    if ({an1, seg1, dp1, fs1} !== 13'b1111_1111111_1_0) begin
      n_fail++; $display("FAIL enable_drop: got %b %b %b %b want 1111 1111111 1 0", an1, seg1, dp1, fs1);
    end
    enable = 1;
    step(1);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({an1, seg1, dp1, fs1} !== 13'b1111_1111111_1_0) begin
      n_fail++; $display("FAIL async_reset: got %b %b %b %b want 1111 1111111 1 0", an1, seg1, dp1, fs1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
    n_cmp++;
    if ({an1, seg1, dp1, fs1} !== {4'b1110, 7'b1111001, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL restart: got %b %b %b %b want 1110 1111001 0 1", an1, seg1, dp1, fs1);
    end
  endtask

  task automatic test_hold();
    int fs_cnt = 0;
    int bad = 0;
    enable = 1; digits = 16'hABCD; lz_suppress = 0; dp_mask = 4'b0001;
    do_reset();
    step(1);
    for (int i = 0; i < 100; i++) begin
      step(0);
      fs_cnt += fs1;
      if ({an1, seg1, dp1} !== {4'b1110, 7'b0100001, 1'b0}) bad++;
    end
    n_cmp++;
    if (bad != 0 || fs_cnt != 0) begin
      n_fail++; $display("FAIL hold: %0d unstable cycles, %0d frame pulses, want 0 and 0", bad, fs_cnt);
    end
  endtask

  task automatic test_random();
    logic [12:0] e, a;
    for (int c = 0; c < 600; c++) begin
      if (rst_n == 1'b0) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int n = 0; n < 4; n++)
          digits[n*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_mask = 4'($urandom_range(0, 15));
        lz_suppress = 1'($urandom_range(0, 1));
      end
      step($urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) begin
        e = exp_out(k);
        a = act_out(k);
        n_cmp++;
        if (a !== e || $countones(a[12:9]) < 3) begin
          n_fail++; $display("FAIL random c%0d inst%0d: got %b want %b", c, k, a, e);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; scan_tick = 0; enable = 0; digits = '0; dp_mask = '0; lz_suppress = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_1234();
    test_lz_suppress();
    test_shadow();
    test_no_blank();
    test_enable_and_reset();
    test_hold();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
